matrix_skew_feeder: RTL and testbench
=====================================

MATRIX_SKEW_FEEDER -- requirements
Module: matrix_skew_feeder

Interface
REQ-001 SHALL have parameters: N, default 4, array dimension; DW, default 8, operand width; TIMEOUT, default 16, maximum drain cycles.
REQ-002 SHALL have a single clock and a synchronous, active-low reset named rst.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- wr_en  in  1  matrix write strobe
- wr_sel  in  1  0 = matrix A, 1 = matrix B
- wr_addr  in  4  row-major index, {row[1:0], col[1:0]}
- wr_data  in  DW  element value
- start  in  1  start-of-run request
- arr_done  in  1  completion flag from the systolic array
- busy  out  1  run in progress
- feed_done  out  1  one-cycle end-of-run pulse
- timeout_err  out  1  sticky timeout flag
- arr_rst  out  1  active-low clear to the array
- out_left1..4  out  DW each  skewed A-row streams
- out_up1..4  out  DW each  skewed B-column streams

Function
REQ-003 SHALL write wr_data into A[row][col] or B[row][col] on a clock edge with wr_en=1, only while in IDLE; writes in any other state are ignored.
REQ-004 SHALL use the FSM states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-005 SHALL move IDLE->CLEAR on start=1; start in any other state is ignored; wr_en and start in the same IDLE cycle commit the write and accept the start.
REQ-006 SHALL stay in CLEAR for exactly 1 cycle with arr_rst=0; arr_rst=1 in every other state.
REQ-007 SHALL stay in FEED for exactly 2N-1=7 cycles while a step counter k runs 0..6, then go to DRAIN.
REQ-008 SHALL drive, in FEED step k, out_left(i) = A[i-1][k-(i-1)] when 0 <= k-(i-1) <= N-1, else 0 (i = 1..4).
REQ-009 SHALL drive, in FEED step k, out_up(j) = B[k-(j-1)][j-1] when 0 <= k-(j-1) <= N-1, else 0 (j = 1..4).
REQ-010 SHALL drive all out_left and out_up to 0 in IDLE, CLEAR, DRAIN and DONE.
REQ-011 SHALL go DRAIN->DONE when arr_done=1, or when the drain counter reaches TIMEOUT cycles; in the timeout case it SHALL set timeout_err.
REQ-012 SHALL ignore arr_done outside DRAIN.
REQ-013 SHALL hold DONE for 1 cycle with feed_done=1, then return to IDLE.
REQ-014 SHALL assert busy=1 in CLEAR, FEED, DRAIN and DONE, and busy=0 in IDLE.
REQ-015 SHALL keep timeout_err sticky until reset or the next accepted start.
REQ-016 SHALL keep matrix contents across runs; only writes and reset change them.
REQ-017 SHALL treat all elements as unsigned; no arithmetic is performed.

Reset
REQ-018 SHALL, when rst=0 on a clock edge, go to IDLE, clear all A and B elements to 0, and zero k and the drain counter.
REQ-019 SHALL hold these outputs during and after reset: busy=0, feed_done=0, timeout_err=0, arr_rst=0 while rst=0 (then 1), all streams 0.
REQ-020 SHALL abort immediately when reset is asserted mid-run, with no feed_done pulse.

Structure
REQ-021 SHALL take N, DW, TIMEOUT, FEED_STEPS=2N-1 and the state enum from shared package systolic_pkg.
REQ-022 SHALL use one sub-module, skew_lane, instantiated 2N times; each instance selects one element by k and lane offset, or 0.

Verification
REQ-023 SHALL pass a reset test: rst=0 for 2 cycles mid-FEED -> IDLE next cycle, all streams 0, busy=0, no feed_done.
REQ-024 SHALL pass a nominal feed: A rows {10,9,7,5},{8,3,3,2},{3,2,10,8},{8,4,3,3}; B columns {3,9,12,3},{12,10,1,10},{4,12,4,12},{10,2,9,18}; start ->
- out_left1 = 10,9,7,5,0,0,0
- out_left2 = 0,8,3,3,2,0,0
- out_up4 = 0,0,0,10,2,9,18
REQ-025 SHALL pass a handshake test: arr_done=1 on the 3rd DRAIN cycle -> feed_done on the next cycle, timeout_err=0.
REQ-026 SHALL pass a timeout test: arr_done held 0 -> DONE after 16 DRAIN cycles, timeout_err=1, cleared by the next start.
REQ-027 SHALL pass an ignored-input test: start and wr_en asserted during FEED -> stream sequence unchanged, memory unchanged.
REQ-028 SHALL pass a same-cycle test: in IDLE, wr_en (A[0][0]=55) with start -> out_left1 step 0 = 55.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared sizing constants and FSM state type for the skew feeder
// Purpose: single source of the array dimension, operand width, drain timeout,
//          feed length and the feeder state encoding.
// Ports:   none (package).
package systolic_pkg;

    // A wavefront through an N x N array needs 2N-1 steps to cover every anti-diagonal.
    function automatic int feed_steps(input int n);
        return 2 * n - 1;
    endfunction

    localparam int N          = 4;
    localparam int DW         = 8;
    localparam int TIMEOUT    = 16;
    localparam int FEED_STEPS = feed_steps(N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feed_state_t;

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - one skewed output lane: picks the element due at step k, else 0
// Purpose: element e of this lane's row/column is presented at step k = LANE + e,
//          which produces the diagonal skew a systolic array expects.
// Ports:   feeding  - high only while the feeder is in FEED
//          k        - current feed step
//          elems    - the lane's N elements packed, element 0 in the low bits
//          lane_out - selected element, or 0 when nothing is due
module skew_lane #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int KW   = 3,
    parameter int LANE = 0
) (
    input  logic            feeding,
    input  logic [KW-1:0]   k,
    input  logic [N*DW-1:0] elems,
    output logic [DW-1:0]   lane_out
);

    always_comb begin
        lane_out = '0;
        if (feeding) begin
            for (int e = 0; e < N; e++) begin
                if (k == KW'(e + LANE)) begin
                    lane_out = elems[e*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_skew_feeder.sv
// rtl/matrix_skew_feeder.sv - holds matrices A and B and feeds them skewed into a systolic array
// Purpose: register-file style loading of A/B while idle, then one run:
//          CLEAR (array reset pulse) -> FEED (2N-1 skewed steps) -> DRAIN (wait for
//          arr_done or timeout) -> DONE (one-cycle feed_done).
// Ports:   clk, rst (sync, active low)
//          wr_en/wr_sel/wr_addr/wr_data - element write, accepted only in IDLE
//          start       - begins a run from IDLE
//          arr_done    - array completion, observed only in DRAIN
//          busy, feed_done, timeout_err (sticky), arr_rst (active-low array clear)
//          out_left1..4 - A rows, out_up1..4 - B columns, skewed by lane index
// The four-lane output ports assume N = 4.
module matrix_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N       = systolic_pkg::N,
    parameter int DW      = systolic_pkg::DW,
    parameter int TIMEOUT = systolic_pkg::TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [2*$clog2(N)-1:0]  wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic                    start,
    input  logic                    arr_done,
    output logic                    busy,
    output logic                    feed_done,
    output logic                    timeout_err,
    output logic                    arr_rst,
    output logic [DW-1:0]           out_left1,
    output logic [DW-1:0]           out_left2,
    output logic [DW-1:0]           out_left3,
    output logic [DW-1:0]           out_left4,
    output logic [DW-1:0]           out_up1,
    output logic [DW-1:0]           out_up2,
    output logic [DW-1:0]           out_up3,
    output logic [DW-1:0]           out_up4
);

    localparam int AW    = $clog2(N);
    localparam int STEPS = feed_steps(N);
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CW    = $clog2(TIMEOUT + 1);

    feed_state_t state_q, state_d;

    logic [KW-1:0] k_q;
    logic [CW-1:0] drain_cnt_q;
    logic          timeout_err_q;

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [N][N];

    logic [AW-1:0] wr_row, wr_col;
    logic          feed_last, drain_expired, feeding;

    assign wr_row = wr_addr[2*AW-1:AW];
    assign wr_col = wr_addr[AW-1:0];

    assign feed_last     = (k_q == KW'(STEPS - 1));
    assign drain_expired = (drain_cnt_q == CW'(TIMEOUT - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (feed_last) state_d = DRAIN;
            DRAIN:   if (arr_done || drain_expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Step counter, drain counter and the sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q           <= '0;
            drain_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            k_q         <= (state_q == FEED)  ? k_q + 1'b1 : '0;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
            if (state_q == IDLE && start) begin
                timeout_err_q <= 1'b0;
            end else if (state_q == DRAIN && !arr_done && drain_expired) begin
                // arr_done arriving on the final drain cycle still counts as a clean finish
                timeout_err_q <= 1'b1;
            end
        end
    end

    // Matrix storage; a write in the same IDLE cycle as start is still committed
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (state_q == IDLE && wr_en) begin
            if (wr_sel) begin
                b_mem[wr_row][wr_col] <= wr_data;
            end else begin
                a_mem[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // Outputs are qualified with rst so they read idle for the whole reset cycle,
    // not just after the first reset edge.
    assign feeding     = rst && (state_q == FEED);
    assign busy        = rst && (state_q != IDLE);
    assign feed_done   = rst && (state_q == DONE);
    assign timeout_err = rst && timeout_err_q;
    assign arr_rst     = rst && (state_q != CLEAR);

    logic [N*DW-1:0] a_row [N];
    logic [N*DW-1:0] b_col [N];
    logic [DW-1:0]   left_s [N];
    logic [DW-1:0]   up_s [N];

    for (genvar i = 0; i < N; i++) begin : g_lane
        for (genvar c = 0; c < N; c++) begin : g_pack
            assign a_row[i][c*DW +: DW] = a_mem[i][c];
            assign b_col[i][c*DW +: DW] = b_mem[c][i];
        end

        skew_lane #(.N(N), .DW(DW), .KW(KW), .LANE(i)) u_left (
            .feeding  (feeding),
            .k        (k_q),
            .elems    (a_row[i]),
            .lane_out (left_s[i])
        );

        skew_lane #(.N(N), .DW(DW), .KW(KW), .LANE(i)) u_up (
            .feeding  (feeding),
            .k        (k_q),
            .elems    (b_col[i]),
            .lane_out (up_s[i])
        );
    end

    assign out_left1 = left_s[0];
    assign out_left2 = left_s[1];
    assign out_left3 = left_s[2];
    assign out_left4 = left_s[3];
    assign out_up1   = up_s[0];
    assign out_up2   = up_s[1];
    assign out_up3   = up_s[2];
    assign out_up4   = up_s[3];

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// tb/tb_matrix_skew_feeder.sv - directed self-checking bench for matrix_skew_feeder
module tb_matrix_skew_feeder;

    logic       clk = 1'b0;
    logic       rst, wr_en, wr_sel, start, arr_done;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy, feed_done, timeout_err, arr_rst;
    logic [7:0] ol [4];
    logic [7:0] ou [4];

    int n_checks = 0;
    int n_pass   = 0;

    int a_m [4][4];
    int b_m [4][4];
    int g_left [7][4];
    int g_up   [7][4];
    int drain_n;

    always #5 clk = ~clk;

    matrix_skew_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .arr_done    (arr_done),
        .busy        (busy),
        .feed_done   (feed_done),
        .timeout_err (timeout_err),
        .arr_rst     (arr_rst),
        .out_left1   (ol[0]),
        .out_left2   (ol[1]),
        .out_left3   (ol[2]),
        .out_left4   (ol[3]),
        .out_up1     (ou[0]),
        .out_up2     (ou[1]),
        .out_up3     (ou[2]),
        .out_up4     (ou[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int exp_left(input int i, input int k);
        int d = k - i;
        return (d >= 0 && d < 4) ? a_m[i][d] : 0;
    endfunction

    function automatic int exp_up(input int j, input int k);
        int d = k - j;
        return (d >= 0 && d < 4) ? b_m[d][j] : 0;
    endfunction

    task automatic load_all();
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    wr_en   = 1'b1;
                    wr_sel  = s[0];
                    wr_addr = 4'(r * 4 + c);
                    wr_data = 8'((s == 0) ? a_m[r][c] : b_m[r][c]);
                    tick();
                end
            end
        end
        wr_en = 1'b0;
    endtask

    // One complete run from IDLE. done_at = drain cycle on which arr_done is raised (0 = never).
    task automatic do_run(input int done_at, input bit inject, input bit pre_we, input int pre_data);
        start   = 1'b1;
        wr_en   = pre_we;
        wr_sel  = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'(pre_data);
        if (pre_we) a_m[0][0] = pre_data;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("clear_busy", 32'(busy), 1);
        check("clear_arr_rst", 32'(arr_rst), 0);
        check("clear_timeout_err", 32'(timeout_err), 0);
        check("clear_left1", 32'(ol[0]), 0);
        for (int s = 0; s < 7; s++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                g_left[s][i] = int'(ol[i]);
                g_up[s][i]   = int'(ou[i]);
                check($sformatf("left%0d_k%0d", i + 1, s), 32'(ol[i]), 32'(exp_left(i, s)));
                check($sformatf("up%0d_k%0d", i + 1, s), 32'(ou[i]), 32'(exp_up(i, s)));
            end
            if (s == 0) check("feed_arr_rst", 32'(arr_rst), 1);
            if (inject && s == 2) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd15;
                wr_data = 8'd99;
            end
            if (s == 3) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
        end
        tick();
        check("drain_busy", 32'(busy), 1);
        check("drain_left1", 32'(ol[0]), 0);
        check("drain_up4", 32'(ou[3]), 0);
        drain_n = 1;
        while (drain_n < 40) begin
            if (drain_n == done_at) arr_done = 1'b1;
            tick();
            arr_done = 1'b0;
            if (feed_done) break;
            drain_n++;
        end
        check("feed_done_seen", 32'(feed_done), 1);
    endtask

    task automatic finish_run();
        tick();
        check("idle_feed_done", 32'(feed_done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int ea [4][4] = '{'{10, 9, 7, 5}, '{8, 3, 3, 2}, '{3, 2, 10, 8}, '{8, 4, 3, 3}};
        int bc [4][4] = '{'{3, 9, 12, 3}, '{12, 10, 1, 10}, '{4, 12, 4, 12}, '{10, 2, 9, 18}};
        int x_l1 [7]  = '{10, 9, 7, 5, 0, 0, 0};
        int x_l2 [7]  = '{0, 8, 3, 3, 2, 0, 0};
        int x_u4 [7]  = '{0, 0, 0, 10, 2, 9, 18};
        int fd_cnt;

        rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; arr_done = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = ea[r][c];
                b_m[r][c] = bc[c][r];
            end

        // Reset state
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_feed_done", 32'(feed_done), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_arr_rst", 32'(arr_rst), 0);
        check("rst_left1", 32'(ol[0]), 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_arr_rst", 32'(arr_rst), 1);
        check("post_rst_busy", 32'(busy), 0);

        // Nominal feed with handshake on the 3rd drain cycle
        load_all();
        do_run(3, 1'b0, 1'b0, 0);
        check("hs_drain_cycles", 32'(drain_n), 3);
        check("hs_timeout_err", 32'(timeout_err), 0);
        finish_run();
        for (int s = 0; s < 7; s++) begin
            check($sformatf("spec_left1_k%0d", s), 32'(g_left[s][0]), 32'(x_l1[s]));
            check($sformatf("spec_left2_k%0d", s), 32'(g_left[s][1]), 32'(x_l2[s]));
            check($sformatf("spec_up4_k%0d", s), 32'(g_up[s][3]), 32'(x_u4[s]));
        end

        // Timeout: no arr_done
        do_run(0, 1'b0, 1'b0, 0);
        check("to_drain_cycles", 32'(drain_n), 16);
        check("to_timeout_err", 32'(timeout_err), 1);
        finish_run();
        check("to_sticky", 32'(timeout_err), 1);

        // Ignored start/write during FEED; next start clears timeout_err in CLEAR
        do_run(2, 1'b1, 1'b0, 0);
        check("ign_drain_cycles", 32'(drain_n), 2);
        check("ign_left4_k6", 32'(g_left[6][3]), 3);
        finish_run();

        // Same-cycle write + start
        do_run(1, 1'b0, 1'b1, 55);
        check("same_left1_k0", 32'(g_left[0][0]), 55);
        finish_run();

        // Reset mid-FEED
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 4; s++) tick();
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b0;
        fd_cnt = 0;
        tick();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_arr_rst", 32'(arr_rst), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("midrst_left%0d", i + 1), 32'(ol[i]), 0);
            check($sformatf("midrst_up%0d", i + 1), 32'(ou[i]), 0);
        end
        if (feed_done) fd_cnt++;
        tick();
        if (feed_done) fd_cnt++;
        rst = 1'b1;
        tick();
        if (feed_done) fd_cnt++;
        check("midrst_no_feed_done", 32'(fd_cnt), 0);
        check("midrst_idle_busy", 32'(busy), 0);

        // Matrices cleared by reset: a run streams only zeros
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = 0;
                b_m[r][c] = 0;
            end
        do_run(1, 1'b0, 1'b0, 0);
        finish_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
